mc_controller: RTL

Multicycle control unit for the RISC-V datapath. A Moore main FSM sequences each instruction through fetch, decode, execute, memory and writeback. It produces the 3-bit `alucontrol` code and operand selects consumed by `alu`. It samples the ALU `flags` bus to resolve branches. It sits beside the shared datapath (single memory, IR, OldPC, ALUOut, Data registers) and owns every write-enable in it.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/alu_dec.sv | 36 +++
 rtl/mc_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RISC-V control path.
// Holds the multicycle FSM state type, the opcodes the controller
// recognises, the 3-bit ALU control codes and the internal aluop codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECUTER,
    ST_EXECUTEI,
    ST_ALUWB,
    ST_BEQ,
    ST_JAL
  } mc_state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU decoder, shared with the single-cycle core.
// Ports:
//   aluop      in  2 : operation class from the main controller
//   funct3     in  3 : IR[14:12]
//   opb5       in  1 : op[5], distinguishes R-type from I-type
//   funct7b5   in  1 : IR[30]
//   alucontrol out 3 : ALU operation code
module alu_dec
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       opb5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; addi may have IR[30] set
          3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the shared RISC-V datapath.
// Moore main FSM (fetch/decode/execute/memory/writeback) plus the ALU
// decoder; pcwrite is the only output that also depends on flags.
// Ports:
//   clk, reset        : rising-edge clock, async active-high reset to FETCH
//   op, funct3, funct7b5 : instruction fields from IR
//   flags             : {V,C,N,Z} from the ALU, only Z is used (BEQ)
//   pcwrite, adrsrc, memwrite, irwrite, regwrite : datapath enables/selects
//   resultsrc, alusrca, alusrcb, immsrc, alucontrol : datapath mux/ALU codes
//   illegal           : one-cycle pulse in DECODE on an unsupported opcode
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic       regwrite,
  output logic       illegal
);

  mc_state_t  state, next;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       unused_flags;

  assign unused_flags = ^flags[3:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= next;
  end

  always_comb begin
    next = ST_FETCH;
    case (state)
      ST_FETCH:  next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: next = ST_MEMADR;
          OP_R:         next = ST_EXECUTER;
          OP_I:         next = ST_EXECUTEI;
          OP_BEQ:       next = ST_BEQ;
          OP_JAL:       next = ST_JAL;
          default:      next = ST_FETCH;
        endcase
      end
      ST_MEMADR:   next = op[5] ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  next = ST_MEMWB;
      ST_EXECUTER: next = ST_ALUWB;
      ST_EXECUTEI: next = ST_ALUWB;
      ST_JAL:      next = ST_ALUWB;
      default:     next = ST_FETCH;
    endcase
  end

  always_comb begin
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    aluop     = ALUOP_ADD;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    case (state)
      ST_FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
      end
      ST_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
      end
      ST_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      ST_MEMREAD: adrsrc = 1'b1;
      ST_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      ST_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      ST_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      ST_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: regwrite = 1'b1;
      ST_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      ST_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcwrite = pcupdate | (branch & flags[0]);

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  alu_dec u_alu_dec (
    .aluop      (aluop),
    .funct3     (funct3),
    .opb5       (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule
